// File: rtl/inst_fetch_pair.sv
// inst_fetch_pair: dual-issue instruction fetch unit.
// Holds the PC, issues word reads to instruction memory, buffers the returned
// words in order and presents two consecutive instructions per cycle to decode.
// A 32'h0 word ends the program. Define FETCH_PERF_EN to add the
// perf_pairs/perf_stall counters.
module inst_fetch_pair #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        pair_valid,
  input  logic        pair_ready,
  output logic [31:0] inst1,
  output logic [31:0] inst2,
  output logic [31:0] pc1,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_pairs,
  output logic [31:0] perf_stall
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  typedef enum logic [1:0] {FETCH, FLUSH, HALT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fifo_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, head_nx;
  logic [CW-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d, pop_n;
  logic [31:0]   pc_q, pc_d, head_pc_q, head_pc_d;
  logic          req_q, req_d;
  logic          push, xfer;

  // Output decode from registered buffer state only
  assign head_nx    = head_q + PW'(1);
  assign pair_valid = (count_q >= CW'(2)) || ((state_q == HALT) && (count_q == CW'(1)));
  assign inst1      = pair_valid ? fifo_q[head_q] : 32'h0;
  assign inst2      = (pair_valid && (count_q >= CW'(2))) ? fifo_q[head_nx] : 32'h0;
  assign pc1        = head_pc_q;
  assign halted     = (state_q == HALT) && (count_q == '0);
  assign imem_req   = req_q;
  assign imem_addr  = pc_q;

  // Next-state: request issue, response handling, pair pop and redirect
  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    drop_d    = drop_q;
    pc_d      = pc_q;
    head_pc_d = head_pc_q;
    push      = 1'b0;
    xfer      = pair_valid && pair_ready;
    pop_n     = (count_q >= CW'(2)) ? CW'(2) : CW'(1);
    // a request issued this cycle is in flight even if a redirect arrives
    outst_d   = outst_q + CW'(req_q) - CW'(imem_rvalid);
    if (req_q) begin
      pc_d = pc_q + 32'd4;
    end

    if (redirect_valid) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      drop_d    = outst_d;
      pc_d      = redirect_pc;
      head_pc_d = redirect_pc;
      state_d   = (outst_d != '0) ? FLUSH : FETCH;
    end else begin
      if (imem_rvalid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else if (imem_rdata == 32'h0) begin
          state_d = HALT;
          drop_d  = outst_d;
        end else begin
          push = 1'b1;
        end
      end
      if ((state_q == FLUSH) && (drop_d == '0)) begin
        state_d = FETCH;
      end
      if (push) begin
        tail_d = tail_q + PW'(1);
      end
      if (xfer) begin
        head_d    = head_q + PW'(pop_n);
        head_pc_d = head_pc_q + (32'(pop_n) << 2);
      end
      count_d = count_q + CW'(push) - (xfer ? pop_n : CW'(0));
    end

    req_d = (state_d == FETCH) && ((SW'(count_d) + SW'(outst_d)) < SW'(DEPTH));
  end

  // State and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      outst_q   <= '0;
      drop_q    <= '0;
      pc_q      <= PC_RESET;
      head_pc_q <= PC_RESET;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      pc_q      <= pc_d;
      head_pc_q <= head_pc_d;
      req_q     <= req_d;
    end
  end

  // Buffer storage; contents are qualified by count so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[tail_q] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  // Delivered-pair and decode-stall counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_pairs <= '0;
      perf_stall <= '0;
    end else begin
      perf_pairs <= perf_pairs + 32'(xfer);
      perf_stall <= perf_stall + 32'(pair_valid && !pair_ready);
    end
  end
`endif

endmodule

// File: doc/inst_fetch_pair.md
# inst_fetch_pair

Dual-issue instruction fetch unit that produces the instruction pairs the dual decoder consumes. It holds the program counter and issues word-sized reads to instruction memory. Returned words go into a DEPTH-entry in-order buffer, and the unit presents two consecutive instructions per cycle on a valid/ready handshake. A 32'h0 word marks end of program and halts fetch. 32'h0 is also the bubble encoding on the output: the decoder forces ALU control to zero for it.

## Interface
- DEPTH, 8, fetch buffer entries; power of 2, ≥4
- PC_RESET, 32'h0, PC after reset
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  read request; memory accepts every request in the cycle it is high
- imem_addr  out  32  byte address of request, word aligned
- imem_rvalid  in  1  read data valid; responses return in request order, ≥1 cycle after request
- imem_rdata  in  32  read data
- redirect_valid  in  1  branch/jump redirect, single-cycle pulse
- redirect_pc  in  32  redirect target, word aligned
- pair_valid  out  1  inst1/inst2 valid to decode
- pair_ready  in  1  decode accepts pair
- inst1  out  32  older instruction
- inst2  out  32  younger instruction, or 32'h0 bubble
- pc1  out  32  address of inst1
- halted  out  1  end-of-program seen and buffer empty

## Operation
- States: FETCH, FLUSH, HALT. Reset enters FETCH with pc=PC_RESET.
- Request rule: in FETCH, imem_req=1 when count+outstanding < DEPTH. Use the registered count and ignore a same-cycle pop. Each request sends imem_addr=pc, then pc+=4 and outstanding+=1.
- Response rule, drop_cnt=0:
  - A nonzero word is pushed.
  - A 32'h0 word is not pushed. State goes to HALT and drop_cnt=outstanding−1, so the remaining in-flight words are discarded.
- Response rule, drop_cnt>0: the word is discarded and drop_cnt decrements.
- Every response decrements outstanding.
- Output:
  - count≥2: pair_valid=1, inst1=buf[head], inst2=buf[head+1], pc1=address of inst1.
  - count=1 in HALT: pair_valid=1, inst2=32'h0.
  - count=1 otherwise: pair_valid=0. The unit waits for the second word.
  - count=0: pair_valid=0.
- Transfer on pair_valid&pair_ready pops 2 entries, or 1 in the odd-final case. Push and pop may occur in the same cycle.
- Redirect, accepted in any state:
  - Buffer is cleared.
  - drop_cnt=outstanding minus any response accepted that same cycle. That response is itself discarded.
  - pc=redirect_pc.
  - State goes to FLUSH if drop_cnt>0, else FETCH.
  - A pair handshake in the redirect cycle counts as delivered.
- FLUSH→FETCH in the cycle drop_cnt reaches 0. The first request to the new pc goes out the following cycle.
- HALT is left only by redirect. halted=1 in HALT when count=0.
- PC wraps modulo 2^32. Buffer pointers wrap modulo DEPTH.

## Timing
- Reset values: imem_req=0, imem_addr=PC_RESET, pair_valid=0, inst1=inst2=0, pc1=PC_RESET, halted=0, count=outstanding=drop_cnt=0.
- First imem_req is in the first rising edge cycle after rst_n deasserts.
- imem_req and imem_addr are registered. pair_valid, inst1, inst2 and pc1 decode from registered buffer state, with no combinational path from pair_ready.
- Minimum latency from response to pair_valid is 1 cycle after the second word of the pair is captured.
- Full throughput is one request per cycle, and one pair per cycle when memory returns two words per pair interval.
- Asynchronous reset mid-operation discards buffer and outstanding state immediately. Responses to pre-reset requests arriving after reset are the environment's responsibility and must not occur.

## Configuration
- FETCH_PERF_EN defined:
  - Adds outputs perf_pairs (32, increments per transfer) and perf_stall (32, increments per cycle with pair_valid&!pair_ready).
  - Both reset to 0 and wrap.
- FETCH_PERF_EN undefined: the ports and counters are absent. Functional behaviour is identical.

## Test plan
- Reset release, memory latency 1, words 0x00500093,0x00100113,… and pair_ready=1 → requests at 0,4,8,… back to back; first pair inst1=0x00500093, inst2=0x00100113, pc1=0.
- pair_ready=0 for 20 cycles → imem_req drops once count+outstanding=8; no word lost; pairs resume in order when ready rises.
- Program of 3 words then 32'h0 → pairs (w0,w1) and (w2,0); halted=1; no further imem_req.
- Redirect to 0x100 with 3 outstanding and latency 4 → 3 responses discarded, FLUSH for 3 response cycles, next request addr 0x100, first pair pc1=0x100.
- Redirect in the same cycle as a response and a pair handshake → the pair counts as delivered, the response is discarded, and the buffer is empty the next cycle.
- rst_n pulsed low mid-stream → all outputs at reset values asynchronously; fetch restarts at PC_RESET. With FETCH_PERF_EN, perf counters read 0.
